// File: rtl/bram_burst_reader_if.sv
// ---------------------------------------------------------------------------
// bram_burst_reader_if
//   Bundles the three buses of the burst reader so they travel as one port.
//   - cmd_*  : burst command channel (valid/ready), start address and length-1
//   - bram_* : single-port BRAM port (en/we/addr/din out, dout in, 1-cycle read)
//   - m_*    : output word stream (valid/ready) with last-word marker
//   - busy   : burst in progress
//   modport master : the burst reader itself
//   modport slave  : the surroundings (command source, BRAM, stream sink)
// ---------------------------------------------------------------------------
interface bram_burst_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
) ();

    // Command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;

    // BRAM port
    logic                  bram_en;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    // Output stream
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    // Status
    logic                  busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, bram_dout, m_ready,
        output cmd_ready, bram_en, bram_we, bram_addr, bram_din,
        output m_valid, m_data, m_last, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, bram_dout, m_ready,
        input  cmd_ready, bram_en, bram_we, bram_addr, bram_din,
        input  m_valid, m_data, m_last, busy
    );

endinterface

// File: rtl/bram_burst_reader.sv
// ---------------------------------------------------------------------------
// bram_burst_reader
//   Read-side master for a single-port BRAM with 1-cycle read latency.
//   A burst command (start address, length-1) is turned into sequential BRAM
//   reads; returned words go through a 4-entry FIFO and are streamed out on a
//   valid/ready interface with the final word flagged by m_last.  Reads are
//   only issued while FIFO occupancy plus reads in flight stays below the
//   FIFO depth, so sink backpressure can never overflow the FIFO.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any burst, drops in-flight reads)
//   bus  : bram_burst_reader_if.master
//          cmd_valid/cmd_ready/cmd_addr/cmd_len  burst command (ready only in IDLE)
//          bram_en/bram_we/bram_addr/bram_din    BRAM request (we, din tied to 0)
//          bram_dout                             BRAM read data, 1 cycle after en
//          m_valid/m_ready/m_data/m_last         output word stream
//          busy                                  command accepted, last word not yet sent
// ---------------------------------------------------------------------------
module bram_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                clk,
    input  logic                rst,
    bram_burst_reader_if.master bus
);

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_WIDTH  = 2;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = LEN_WIDTH'(0);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [3:0]            OCC_LIMIT = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // FSM
    state_t state_q, state_d;

    // Read issue datapath
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;   // address of the next read to issue
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;   // reads still to issue after bram_addr_q
    logic                  bram_en_q, bram_en_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic                  en_last_q, en_last_d;       // the read in bram_en_q is the burst's final word

    // Read return pipeline: bram_dout is valid in the cycle after bram_en
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;

    // Output FIFO, last flag stored per entry
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic [FIFO_DEPTH-1:0]                 fifo_last_q, fifo_last_d;
    logic [PTR_WIDTH-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [2:0]                            count_q, count_d;

    // Registered status outputs
    logic busy_q, busy_d;
    logic cmd_ready_q, cmd_ready_d;

    // Combinational helpers
    logic       cmd_hs_s;
    logic       issue_s;
    logic [1:0] inflight_s;
    logic [3:0] occupancy_s;
    logic       room_s;
    logic       push_s;
    logic       pop_s;
    logic       m_valid_s;
    logic       head_last_s;

    assign cmd_hs_s    = bus.cmd_valid & cmd_ready_q;
    assign m_valid_s   = (count_q != 3'd0);
    assign head_last_s = fifo_last_q[rd_ptr_q];
    assign push_s      = rd_valid_q;
    assign pop_s       = m_valid_s & bus.m_ready;

    // Occupancy is evaluated on registered state, so a read issued now is
    // already counted as in flight when the next issue is decided.
    assign inflight_s  = {1'b0, bram_en_q} + {1'b0, rd_valid_q};
    assign occupancy_s = {1'b0, count_q} + {2'b00, inflight_s};
    assign room_s      = (occupancy_s < OCC_LIMIT);

    // Issue a follow-on read while words remain and the FIFO can take it
    assign issue_s = (state_q == ST_ISSUE) && (remaining_q != LEN_ZERO) && room_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // The first read goes out straight from the handshake, so a
                // one-word burst has nothing left to issue.
                if (cmd_hs_s) begin
                    if (bus.cmd_len == LEN_ZERO) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_s && (remaining_q == LEN_ONE)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: status flags follow the upcoming state so they are registered
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // Read issue: address/length bookkeeping and BRAM request generation
    always_comb begin
        bram_en_d   = 1'b0;
        en_last_d   = 1'b0;
        bram_addr_d = bram_addr_q;
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        if (cmd_hs_s) begin
            bram_en_d   = 1'b1;
            en_last_d   = (bus.cmd_len == LEN_ZERO);
            bram_addr_d = bus.cmd_addr;
            next_addr_d = bus.cmd_addr + ADDR_ONE;
            remaining_d = bus.cmd_len;
        end else if (issue_s) begin
            bram_en_d   = 1'b1;
            en_last_d   = (remaining_q == LEN_ONE);
            bram_addr_d = next_addr_q;
            next_addr_d = next_addr_q + ADDR_ONE;
            remaining_d = remaining_q - LEN_ONE;
        end else begin
            bram_en_d   = 1'b0;
            en_last_d   = 1'b0;
        end
    end

    // Read return: data arrives one cycle after the request
    always_comb begin
        rd_valid_d = bram_en_q;
        rd_last_d  = en_last_q;
    end

    // FIFO: write returned data, pop on stream transfer, both in one cycle allowed
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        if (push_s) begin
            fifo_data_d[wr_ptr_q] = bus.bram_dout;
            fifo_last_d[wr_ptr_q] = rd_last_q;
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end else begin
            wr_ptr_d              = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Datapath, pipeline and FIFO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_en_q   <= 1'b0;
            en_last_q   <= 1'b0;
            bram_addr_q <= ADDR_ZERO;
            next_addr_q <= ADDR_ZERO;
            remaining_q <= LEN_ZERO;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            fifo_data_q <= {(FIFO_DEPTH*DATA_WIDTH){1'b0}};
            fifo_last_q <= {FIFO_DEPTH{1'b0}};
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            bram_en_q   <= bram_en_d;
            en_last_q   <= en_last_d;
            bram_addr_q <= bram_addr_d;
            next_addr_q <= next_addr_d;
            remaining_q <= remaining_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Port drive; the stream presents the FIFO head, which holds until popped
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.bram_en   = bram_en_q;
    assign bus.bram_we   = 1'b0;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = {DATA_WIDTH{1'b0}};
    assign bus.m_valid   = m_valid_s;
    assign bus.m_data    = fifo_data_q[rd_ptr_q];
    assign bus.m_last    = head_last_s;
    assign bus.busy      = busy_q;

endmodule
